// File: rtl/sprite_pkg.sv
// Sprite attribute layout, hit record and scan states shared by
// the scanner, the sprite driver and the attribute RAM writer.
package sprite_pkg;

  localparam int NUM_SPRITE = 32;
  localparam int MAX_HITS   = 8;
  localparam int SPRITE_H   = 16;
  localparam int IW         = $clog2(NUM_SPRITE);

  typedef struct packed {
    logic       vis;
    logic       flip;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] rsvd;
    logic [7:0] tile;
  } sprite_attr_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [9:0]    x;
    logic [3:0]    row;
    logic [7:0]    tile;
    logic          flip;
  } sprite_hit_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EVAL  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/sprite_scanner.sv
// Per-scanline sprite evaluator: walks the attribute RAM and hands
// matching sprites to the pixel fetcher in index order.
import sprite_pkg::*;

module sprite_scanner #(
  parameter int NUM_SPRITE = sprite_pkg::NUM_SPRITE,
  parameter int MAX_HITS   = sprite_pkg::MAX_HITS,
  parameter int SPRITE_H   = sprite_pkg::SPRITE_H,
  localparam int IW        = $clog2(NUM_SPRITE),
  localparam int CW        = $clog2(MAX_HITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [9:0]    line,
  output logic [IW-1:0] attr_ra,
  input  logic [31:0]   attr_q,
  output logic          hit_valid,
  input  logic          hit_ready,
  output logic [IW-1:0] hit_idx,
  output logic [9:0]    hit_x,
  output logic [3:0]    hit_row,
  output logic [7:0]    hit_tile,
  output logic          hit_flip,
  output logic          busy,
  output logic          scan_done,
  output logic          overflow,
  output logic          missed_line
);

  scan_state_t   state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [9:0]    line_r;

  sprite_attr_t  attr;
  logic [10:0]   diff;
  logic          match;
  logic          last;
  logic          full;
  logic          unused_rsvd;

  assign attr        = sprite_attr_t'(attr_q);
  assign unused_rsvd = ^attr.rsvd;

  // Borrow out means line_r < y: a sprite never wraps past row 1023.
  assign diff  = {1'b0, line_r} - {1'b0, attr.y};
  assign match = attr.vis && !diff[10]
              && (diff[9:0] < 10'(SPRITE_H));

  assign last      = idx == IW'(NUM_SPRITE - 1);
  assign full      = cnt == CW'(MAX_HITS);
  assign attr_ra   = idx;
  assign busy      = state != IDLE;
  assign scan_done = state == DONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      line_r      <= '0;
      overflow    <= 1'b0;
      missed_line <= 1'b0;
      hit_valid   <= 1'b0;
      hit_idx     <= '0;
      hit_x       <= '0;
      hit_row     <= '0;
      hit_tile    <= '0;
      hit_flip    <= 1'b0;
    end else begin
      missed_line <= line_start && busy;
      unique case (state)
        IDLE: begin
          if (line_start) begin
            line_r   <= line;
            idx      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= EVAL;
        EVAL: begin
          if (match && full) begin
            overflow <= 1'b1;
            state    <= DONE;
          end else if (match) begin
            hit_idx   <= idx;
            hit_x     <= attr.x;
            hit_row   <= diff[3:0];
            hit_tile  <= attr.tile;
            hit_flip  <= attr.flip;
            hit_valid <= 1'b1;
            cnt       <= cnt + 1'b1;
            state     <= EMIT;
          end else if (last) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE;
          end
        end
        EMIT: begin
          if (hit_ready) begin
            hit_valid <= 1'b0;
            if (last) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
